// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor: pipeline hold encodings,
// jump-enable level and the 2-bit saturating counter update.
package bpu_pkg;

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ID   = 3'b011;

    localparam logic JUMP_ENABLE = 1'b1;

    typedef logic [31:0] inst_addr_t;

    // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
        if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_table.sv
// Register-array storage for the predictor: valid, 2-bit counter, tag, target.
// One asynchronous read port, one write port that applies the counter update.
module bpu_table
    import bpu_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic                     rd_valid,
    output logic [1:0]               rd_ctr,
    output logic [30-IDX_W-1:0]      rd_tag,
    output inst_addr_t               rd_target,
    input  logic                     we,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic                     wr_taken,
    input  logic [30-IDX_W-1:0]      wr_tag,
    input  inst_addr_t               wr_target
);

    localparam int         TAG_W     = 30 - IDX_W;
    localparam int         DEPTH     = 1 << IDX_W;
    localparam logic [1:0] CTR_RESET = 2'b01;

    logic             valid  [DEPTH];
    logic [1:0]       ctr    [DEPTH];
    logic [TAG_W-1:0] tag    [DEPTH];
    inst_addr_t       target [DEPTH];

    assign rd_valid  = valid[rd_idx];
    assign rd_ctr    = ctr[rd_idx];
    assign rd_tag    = tag[rd_idx];
    assign rd_target = target[rd_idx];

    // NOTE: the whole array is cleared on reset because a reset must discard
    // all branch history; valid alone would suffice for correctness, but the
    // counters also have to restart at weak-NT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i]  <= 1'b0;
                ctr[i]    <= CTR_RESET;
                tag[i]    <= '0;
                target[i] <= '0;
            end
        end else if (we) begin
            // NOTE: non-blocking writes keep the async read port returning the
            // pre-update entry for the rest of this cycle.
            ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
            // Not-taken outcomes never touch the BTB fields, even on a tag miss.
            if (wr_taken) begin
                valid[wr_idx]  <= 1'b1;
                tag[wr_idx]    <= wr_tag;
                target[wr_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/bpu.sv
// Dynamic branch predictor: combinational fetch-side lookup, prediction
// tracking down to EX, and training from the EX-stage branch outcome.
module bpu
    import bpu_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  inst_addr_t pc_i,
    input  logic [2:0] hold_flag_i,
    output logic       predict_taken_o,
    output inst_addr_t predict_addr_o,
    output logic       bp_result_o,
    input  logic       need_predict_i,
    input  logic       jump_act_i,
    input  inst_addr_t inst_addr_i,
    input  inst_addr_t jump_addr_i
);

    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag_pc;
    logic             rd_valid;
    logic [1:0]       rd_ctr;
    logic [TAG_W-1:0] rd_tag;
    inst_addr_t       rd_target;
    logic             hit;
    logic             s_id;
    logic             s_ex;
    logic             unused_bits;

    assign rd_idx    = pc_i[IDX_W+1:2];
    assign rd_tag_pc = pc_i[31:IDX_W+2];

    bpu_table #(
        .IDX_W(IDX_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_ctr    (rd_ctr),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .we        (need_predict_i),
        .wr_idx    (inst_addr_i[IDX_W+1:2]),
        .wr_taken  (jump_act_i == JUMP_ENABLE),
        .wr_tag    (inst_addr_i[31:IDX_W+2]),
        .wr_target (jump_addr_i)
    );

    // The tag spans every upper PC bit, so a hit is an exact PC match.
    assign hit             = rd_valid && (rd_tag == rd_tag_pc);
    assign predict_taken_o = hit && rd_ctr[1];
    assign predict_addr_o  = predict_taken_o ? rd_target : 32'h0;

    // Holds at or above If/Id squash the stage, so its prediction is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_id <= 1'b0;
            s_ex <= 1'b0;
        end else begin
            s_id <= (hold_flag_i >= HOLD_IF) ? 1'b0 : predict_taken_o;
            s_ex <= (hold_flag_i >= HOLD_ID) ? 1'b0 : s_id;
        end
    end

    assign bp_result_o = s_ex & need_predict_i;

    // Instructions are word aligned; the low address bits carry no information.
    assign unused_bits = ^{pc_i[1:0], inst_addr_i[1:0]};

endmodule

// File: tb/tb_bpu.sv
// Directed self-checking bench for bpu: lookup, training, saturation,
// aliasing, hold handling and asynchronous reset.
module tb_bpu;
    import bpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic [2:0]  hold_flag_i;
    logic        predict_taken_o;
    logic [31:0] predict_addr_o;
    logic        bp_result_o;
    logic        need_predict_i;
    logic        jump_act_i;
    logic [31:0] inst_addr_i;
    logic [31:0] jump_addr_i;

    int compared   = 0;
    int mismatched = 0;

    bpu #(.IDX_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .hold_flag_i     (hold_flag_i),
        .predict_taken_o (predict_taken_o),
        .predict_addr_o  (predict_addr_o),
        .bp_result_o     (bp_result_o),
        .need_predict_i  (need_predict_i),
        .jump_act_i      (jump_act_i),
        .inst_addr_i     (inst_addr_i),
        .jump_addr_i     (jump_addr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] addr, input logic taken, input logic [31:0] tgt);
        inst_addr_i    = addr;
        jump_act_i     = taken;
        jump_addr_i    = tgt;
        need_predict_i = 1'b1;
        step();
        need_predict_i = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        pc_i           = 32'h100;
        hold_flag_i    = HOLD_NONE;
        need_predict_i = 1'b0;
        jump_act_i     = 1'b0;
        inst_addr_i    = 32'h0;
        jump_addr_i    = 32'h0;

        #12;
        check("rst_taken", {31'b0, predict_taken_o}, 32'h0);
        check("rst_addr", predict_addr_o, 32'h0);
        check("rst_bp", {31'b0, bp_result_o}, 32'h0);
        rst = 1'b1;
        step();
        check("cold_nt", {31'b0, predict_taken_o}, 32'h0);

        // Same-cycle update of idx 0 (01->10): lookup still sees the old entry.
        inst_addr_i = 32'h100; jump_act_i = 1'b1; jump_addr_i = 32'h80; need_predict_i = 1'b1;
        #1;
        check("same_cycle_nt", {31'b0, predict_taken_o}, 32'h0);
        step();
        need_predict_i = 1'b0;
        #1;
        check("train1_taken", {31'b0, predict_taken_o}, 32'h1);
        check("train1_addr", predict_addr_o, 32'h80);

        // Prediction travels ID -> EX in two clocks with no hold.
        step();
        step();
        #1;
        check("bp_no_strobe", {31'b0, bp_result_o}, 32'h0);
        inst_addr_i = 32'h100; jump_act_i = 1'b1; jump_addr_i = 32'h80; need_predict_i = 1'b1;
        #1;
        check("bp_result", {31'b0, bp_result_o}, 32'h1);
        step();                 // ctr 10 -> 11
        step();                 // stays 11
        step();                 // stays 11
        need_predict_i = 1'b0;

        train(32'h100, 1'b0, 32'h0);   // 11 -> 10
        #1;
        check("nt1_still_taken", {31'b0, predict_taken_o}, 32'h1);
        train(32'h100, 1'b0, 32'h0);   // 10 -> 01
        #1;
        check("nt2_predict_nt", {31'b0, predict_taken_o}, 32'h0);
        check("nt2_addr_zero", predict_addr_o, 32'h0);
        train(32'h100, 1'b0, 32'h0);   // 01 -> 00
        train(32'h100, 1'b0, 32'h0);   // stays 00
        #1;
        check("sat_low_nt", {31'b0, predict_taken_o}, 32'h0);
        train(32'h100, 1'b1, 32'h80);  // 00 -> 01
        #1;
        check("from00_weak_nt", {31'b0, predict_taken_o}, 32'h0);
        train(32'h100, 1'b1, 32'h80);  // 01 -> 10
        #1;
        check("back_to_taken", {31'b0, predict_taken_o}, 32'h1);

        // Aliasing on idx 0: 0x140 misses until trained, then evicts 0x100.
        pc_i = 32'h140;
        #1;
        check("alias_miss", {31'b0, predict_taken_o}, 32'h0);
        check("alias_miss_addr", predict_addr_o, 32'h0);
        train(32'h140, 1'b1, 32'h200); // ctr 10 -> 11, tag/target replaced
        #1;
        check("alias_taken", {31'b0, predict_taken_o}, 32'h1);
        check("alias_addr", predict_addr_o, 32'h200);
        pc_i = 32'h100;
        #1;
        check("evicted_miss", {31'b0, predict_taken_o}, 32'h0);
        train(32'h100, 1'b0, 32'h0);   // tag miss: ctr 11 -> 10, BTB intact
        pc_i = 32'h140;
        #1;
        check("nt_miss_btb_kept", {31'b0, predict_taken_o}, 32'h1);
        check("nt_miss_addr_kept", predict_addr_o, 32'h200);

        // Hold_Id on the edge after a taken fetch squashes both stages.
        inst_addr_i = 32'h4; jump_act_i = 1'b0;
        pc_i = 32'h0;
        step();
        step();
        pc_i = 32'h140;
        step();                 // s_id = 1
        pc_i = 32'h0; hold_flag_i = HOLD_ID;
        step();                 // s_id = 0, s_ex = 0
        hold_flag_i = HOLD_NONE; need_predict_i = 1'b1;
        #1;
        check("hold_id_bp", {31'b0, bp_result_o}, 32'h0);
        need_predict_i = 1'b0;

        // Hold_If clears s_id but lets the existing s_id move into EX.
        pc_i = 32'h140;
        step();                 // s_id = 1
        pc_i = 32'h0; hold_flag_i = HOLD_IF;
        step();                 // s_ex = 1, s_id = 0
        hold_flag_i = HOLD_NONE; need_predict_i = 1'b1;
        #1;
        check("hold_if_passes", {31'b0, bp_result_o}, 32'h1);
        need_predict_i = 1'b0;
        step();                 // s_ex = 0
        need_predict_i = 1'b1;
        #1;
        check("hold_if_cleared", {31'b0, bp_result_o}, 32'h0);
        need_predict_i = 1'b0;

        // Hold_Pc leaves tracking untouched.
        pc_i = 32'h140; hold_flag_i = HOLD_PC;
        step();
        step();
        need_predict_i = 1'b1;
        #1;
        check("hold_pc_bp", {31'b0, bp_result_o}, 32'h1);
        hold_flag_i = HOLD_NONE;

        // Asynchronous reset mid-stream discards everything immediately.
        check("pre_rst_taken", {31'b0, predict_taken_o}, 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_taken", {31'b0, predict_taken_o}, 32'h0);
        check("mid_rst_addr", predict_addr_o, 32'h0);
        check("mid_rst_bp", {31'b0, bp_result_o}, 32'h0);
        #2;
        rst = 1'b1;
        need_predict_i = 1'b0;
        step();
        pc_i = 32'h100;
        #1;
        check("post_rst_100_nt", {31'b0, predict_taken_o}, 32'h0);
        pc_i = 32'h140;
        #1;
        check("post_rst_140_nt", {31'b0, predict_taken_o}, 32'h0);
        check("post_rst_140_addr", predict_addr_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
